logic_gate_bist: RTL and testbench

Built-in self-test sequencer for the two-input `logic_gate` unit. On a start pulse it drives the four input combinations onto the gate's `a`/`b` inputs, waits a settle interval, samples the six gate outputs and compares them against the golden truth table. It reports pass/fail, an error count and the first failing vector. It sits beside `logic_gate` in the datapath and owns its inputs during a run.

---
 rtl/logic_gate_pkg.sv | 32 +++
 rtl/logic_gate_bist.sv | 178 +++++++++++++++++
 tb/tb_logic_gate_bist.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic_gate BIST: FSM encoding, gate_out bit map and golden model.
package logic_gate_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } bist_state_e;

    localparam int unsigned AND_IDX     = 0;
    localparam int unsigned OR_IDX      = 1;
    localparam int unsigned XOR_IDX     = 2;
    localparam int unsigned XNOR_IDX    = 3;
    localparam int unsigned NAND_IDX    = 4;
    localparam int unsigned NOTB_IDX    = 5;
    localparam int unsigned NUM_GATES   = 6;
    localparam int unsigned NUM_VECTORS = 4;

    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] e;
        e           = '0;
        e[AND_IDX]  = a & b;
        e[OR_IDX]   = a | b;
        e[XOR_IDX]  = a ^ b;
        e[XNOR_IDX] = ~(a ^ b);
        e[NAND_IDX] = ~(a & b);
        e[NOTB_IDX] = ~b;
        return e;
    endfunction

endpackage

// File: rtl/logic_gate_bist.sv
// BIST sequencer for logic_gate: walks all {a,b} vectors, checks the six outputs against the
// golden table and reports pass/fail, a saturating error count and the first failing vector.
module logic_gate_bist
    import logic_gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 gate_a,
    output logic                 gate_b,
    input  logic [NUM_GATES-1:0] gate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [1:0]           first_fail_vec,
    output logic [NUM_GATES-1:0] first_fail_mask
);

    localparam int unsigned CntW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LoopW = $clog2(LOOPS + 1);

    bist_state_e state_q, state_d;

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           vec_q, vec_d;
    logic [LoopW-1:0]     loop_q, loop_d;
    logic                 gate_a_q, gate_a_d;
    logic                 gate_b_q, gate_b_d;
    logic                 pass_q, pass_d;
    logic [7:0]           err_q, err_d;
    logic [1:0]           ff_vec_q, ff_vec_d;
    logic [NUM_GATES-1:0] ff_mask_q, ff_mask_d;

    logic [NUM_GATES-1:0] mismatch_mask;
    logic                 last_vec;

    assign mismatch_mask = gate_out ^ expected_gates(vec_q[1], vec_q[0]);
    assign last_vec      = (vec_q == 2'(NUM_VECTORS - 1)) && (loop_q == LoopW'(LOOPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start && !abort) state_d = StSettle;
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StCheck;
                end
            end
            StCheck:  begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last_vec) begin
                    state_d = StDone;
                end else begin
                    state_d = StSettle;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StSettle) || (state_q == StCheck);
        done = (state_q == StDone);
    end

    always_comb begin
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        loop_d    = loop_q;
        gate_a_d  = gate_a_q;
        gate_b_d  = gate_b_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ff_vec_d  = ff_vec_q;
        ff_mask_d = ff_mask_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    cnt_d     = CntW'(SETTLE_CYCLES - 1);
                    vec_d     = '0;
                    loop_d    = '0;
                    gate_a_d  = 1'b0;
                    gate_b_d  = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    ff_vec_d  = '0;
                    ff_mask_d = '0;
                end
            end
            StSettle: begin
                if (abort) begin
                    pass_d   = 1'b0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCheck: begin
                if (abort) begin
                    pass_d   = 1'b0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else begin
                    if (mismatch_mask != '0) begin
                        // Counter saturates, so a zero count reliably marks the first miss.
                        if (err_q == 8'd0) begin
                            ff_vec_d  = vec_q;
                            ff_mask_d = mismatch_mask;
                        end
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                    if (last_vec) begin
                        pass_d   = (err_d == 8'd0);
                        gate_a_d = 1'b0;
                        gate_b_d = 1'b0;
                    end else begin
                        vec_d    = vec_q + 2'd1;
                        if (vec_q == 2'(NUM_VECTORS - 1)) loop_d = loop_q + LoopW'(1);
                        cnt_d    = CntW'(SETTLE_CYCLES - 1);
                        gate_a_d = vec_d[1];
                        gate_b_d = vec_d[0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            vec_q     <= '0;
            loop_q    <= '0;
            gate_a_q  <= 1'b0;
            gate_b_q  <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ff_vec_q  <= '0;
            ff_mask_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            loop_q    <= loop_d;
            gate_a_q  <= gate_a_d;
            gate_b_q  <= gate_b_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ff_vec_q  <= ff_vec_d;
            ff_mask_q <= ff_mask_d;
        end
    end

    assign gate_a          = gate_a_q;
    assign gate_b          = gate_b_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ff_vec_q;
    assign first_fail_mask = ff_mask_q;

endmodule

// File: tb/tb_logic_gate_bist.sv
// Directed bench for logic_gate_bist: a behavioural gate with injectable faults drives gate_out.
module tb_logic_gate_bist;
    import logic_gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, start3, abort3;
    int         fault_mode;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_seen;

    logic       gate_a, gate_b, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] ffv;
    logic [5:0] ffm, gate_out;

    logic       gate_a3, gate_b3, busy3, done3, pass3;
    logic [7:0] err_count3;
    logic [1:0] ffv3;
    logic [5:0] ffm3, gate_out3;

    // 0: good gate, 1: and stuck at 0, 2: notb wired to b
    function automatic logic [5:0] gate_model(input logic a, input logic b, input int mode);
        logic [5:0] g;
        g[0] = a & b;
        g[1] = a | b;
        g[2] = a ^ b;
        g[3] = ~(a ^ b);
        g[4] = ~(a & b);
        g[5] = ~b;
        if (mode == 1) g[0] = 1'b0;
        if (mode == 2) g[5] = b;
        return g;
    endfunction

    always_comb gate_out  = gate_model(gate_a, gate_b, fault_mode);
    always_comb gate_out3 = gate_model(gate_a3, gate_b3, fault_mode);

    logic_gate_bist dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .gate_a          (gate_a),
        .gate_b          (gate_b),
        .gate_out        (gate_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_vec  (ffv),
        .first_fail_mask (ffm)
    );

    logic_gate_bist #(
        .SETTLE_CYCLES (2),
        .LOOPS         (3)
    ) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start3),
        .abort           (abort3),
        .gate_a          (gate_a3),
        .gate_b          (gate_b3),
        .gate_out        (gate_out3),
        .busy            (busy3),
        .done            (done3),
        .pass            (pass3),
        .err_count       (err_count3),
        .first_fail_vec  (ffv3),
        .first_fail_mask (ffm3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 1 (just after the edge that samples start).
    task automatic start_run();
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (!done && cyc < limit) step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; fault_mode = 0;
        #3;
        check("rst_gate_a", gate_a, 1'b0);
        check("rst_gate_b", gate_b, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 8'd0);
        check("rst_ffv", ffv, 2'd0);
        check("rst_ffm", ffm, 6'd0);
        check("rst_busy3", busy3, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Package golden model against the bench's own truth table
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            check("pkg_golden", expected_gates(vv[1], vv[0]), gate_model(vv[1], vv[0], 0));
        end

        // Good gate: vector walk, busy window, done at cycle 13
        fault_mode = 0;
        start_run();
        for (int c = 1; c <= 12; c++) begin
            check("good_vec", {gate_a, gate_b}, 32'((c - 1) / 3));
            check("good_busy", busy, 1'b1);
            check("good_nodone", done, 1'b0);
            step();
        end
        check("good_done13", done, 1'b1);
        check("good_pass", pass, 1'b1);
        check("good_err", err_count, 8'd0);
        check("good_gates_idle", {gate_a, gate_b}, 2'b00);
        check("good_busy_low", busy, 1'b0);
        step();
        check("good_done_pulse", done, 1'b0);
        check("good_pass_held", pass, 1'b1);

        // AND stuck at 0
        fault_mode = 1;
        start_run();
        wait_done(60);
        check("and_done_cyc", cyc, 13);
        check("and_err", err_count, 8'd1);
        check("and_ffv", ffv, 2'b11);
        check("and_ffm", ffm, 6'b000001);
        check("and_pass", pass, 1'b0);

        // New start clears results, good rerun passes
        fault_mode = 0;
        step();
        check("held_err", err_count, 8'd1);
        start_run();
        check("clr_err", err_count, 8'd0);
        check("clr_ffv", ffv, 2'd0);
        check("clr_ffm", ffm, 6'd0);
        wait_done(60);
        check("rerun_done_cyc", cyc, 13);
        check("rerun_pass", pass, 1'b1);

        // start re-pulsed while busy is ignored
        step();
        start_run();
        while (cyc < 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);
        check("repulse_done_cyc", cyc, 13);
        check("repulse_pass", pass, 1'b1);

        // Abort at cycle 5 with notb miswired: vector 00 already counted
        fault_mode = 2;
        step();
        start_run();
        while (cyc < 5) step();
        check("abort_pre_vec", {gate_a, gate_b}, 2'b01);
        check("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_gates", {gate_a, gate_b}, 2'b00);
        check("abort_pass", pass, 1'b0);
        check("abort_err", err_count, 8'd1);
        check("abort_ffv", ffv, 2'b00);
        check("abort_ffm", ffm, 6'b100000);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);

        // start+abort together in IDLE: stays idle, results untouched
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 1'b0);
        step();
        check("sa_busy2", busy, 1'b0);
        check("sa_err_kept", err_count, 8'd1);

        // LOOPS=3 with notb miswired: every vector fails
        fault_mode = 2;
        start3 = 1'b1;
        cyc = 0;
        step();
        start3 = 1'b0;
        while (!done3 && cyc < 100) step();
        check("l3_done_cyc", cyc, 37);
        check("l3_err", err_count3, 8'd12);
        check("l3_ffv", ffv3, 2'b00);
        check("l3_ffm", ffm3, 6'b100000);
        check("l3_pass", pass3, 1'b0);

        // Asynchronous reset at cycle 7 mid-run
        step();
        start_run();
        while (cyc < 7) step();
        check("rst7_busy_pre", busy, 1'b1);
        check("rst7_err_pre", err_count, 8'd2);
        rst_n = 1'b0;
        #1;
        check("rst7_gates", {gate_a, gate_b}, 2'b00);
        check("rst7_busy", busy, 1'b0);
        check("rst7_done", done, 1'b0);
        check("rst7_pass", pass, 1'b0);
        check("rst7_err", err_count, 8'd0);
        check("rst7_ffm", ffm, 6'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst7_idle", busy, 1'b0);
        fault_mode = 0;
        start_run();
        wait_done(60);
        check("rst7_done_cyc", cyc, 13);
        check("rst7_rerun_pass", pass, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
